// File: rtl/rc_lsu_replay_fifo_if.sv
// Bundle handshake between the primary-core capture side and the shadow-core replay side.
interface rc_lsu_replay_fifo_if #(
  parameter int DW = 70
);
  logic          in_vld;
  logic [DW-1:0] in_dat;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_dat;

  modport master (output in_vld, in_dat, out_rdy, input out_vld, out_dat);
  modport slave  (input in_vld, in_dat, out_rdy, output out_vld, out_dat);
endinterface

// File: rtl/rc_lsu_replay_fifo.sv
// Lagged in-order replay FIFO feeding LSU bundles from the primary core to the shadow core.
module rc_lsu_replay_fifo #(
  parameter int DW    = 70,
  parameter int DEPTH = 4,
  parameter int LAG   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lden,
  input  logic                         flush,
  input  logic                         err_clr,
  rc_lsu_replay_fifo_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [3:0] LAG_A = 4'(LAG);

  logic [DW-1:0]    mem [DEPTH];
  logic [3:0]       age [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_req;
  logic             push_acc;
  logic             pop;
  logic             ovf_set;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign bus.out_vld = !empty && (age[rd_ptr] >= LAG_A);
  assign bus.out_dat = mem[rd_ptr];
  assign pop         = bus.out_vld & bus.out_rdy;
  assign push_req    = lden & bus.in_vld;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc    = push_req & (~full | pop) & ~flush;
  assign ovf_set     = push_req & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
      ovf_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
      ovf_err <= ovf_err & ~err_clr;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (lden && ent_vld[i] && (age[i] < LAG_A))
          age[i] <= age[i] + 4'd1;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      // Placed after the pop/aging updates so a slot reused this cycle starts fresh.
      if (push_acc) begin
        ent_vld[wr_ptr] <= 1'b1;
        age[wr_ptr]     <= '0;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && !rst) mem[wr_ptr] <= bus.in_dat;
  end
endmodule

// File: tb/tb_rc_lsu_replay_fifo.sv
// Directed bench for rc_lsu_replay_fifo with a data scoreboard on the replay port.
module tb_rc_lsu_replay_fifo;
  localparam int DW = 70;

  logic       clk = 1'b0;
  logic       rst;
  logic       lden;
  logic       flush;
  logic       err_clr;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       ovf_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] q[$];

  rc_lsu_replay_fifo_if #(.DW(DW)) bus ();

  rc_lsu_replay_fifo #(.DW(DW), .DEPTH(4), .LAG(2)) dut (
    .clk(clk), .rst(rst), .lden(lden), .flush(flush), .err_clr(err_clr),
    .bus(bus), .count(count), .full(full), .empty(empty), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [DW-1:0] d, input bit acc);
    bus.in_vld = 1'b1;
    bus.in_dat = d;
    if (acc) q.push_back(d);
    step();
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (count != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout", 80'(n < 40), 80'd1);
  endtask

  // Replay port: every handshake must deliver the oldest outstanding bundle.
  always @(negedge clk) begin
    if (!rst && !flush && bus.out_vld && bus.out_rdy) begin
      logic [DW-1:0] e;
      e = (q.size() != 0) ? q.pop_front() : 'x;
      chk("sb_data", 80'(bus.out_dat), 80'(e));
    end
  end

  initial begin
    rst = 1'b1; lden = 1'b0; flush = 1'b0; err_clr = 1'b0;
    bus.in_vld = 1'b0; bus.in_dat = '0; bus.out_rdy = 1'b0;
    step(); step();
    chk("rst_count", 80'(count), 80'd0);
    chk("rst_empty", 80'(empty), 80'd1);
    chk("rst_full", 80'(full), 80'd0);
    chk("rst_out_vld", 80'(bus.out_vld), 80'd0);
    chk("rst_ovf", 80'(ovf_err), 80'd0);
    rst = 1'b0;

    // single bundle latency
    lden = 1'b1; bus.out_rdy = 1'b1;
    push1(70'h15, 1'b1);
    chk("t1_vld_c1", 80'(bus.out_vld), 80'd0);
    step();
    chk("t1_vld_c2", 80'(bus.out_vld), 80'd0);
    step();
    chk("t1_vld_c3", 80'(bus.out_vld), 80'd1);
    chk("t1_dat_c3", 80'(bus.out_dat), 80'h15);
    step();
    chk("t1_count_c4", 80'(count), 80'd0);

    // back-to-back ordering
    push1(70'hA, 1'b1);
    chk("t2_count_c1", 80'(count), 80'd1);
    push1(70'hB, 1'b1);
    chk("t2_count_c2", 80'(count), 80'd2);
    push1(70'hC, 1'b1);
    chk("t2_count_c3", 80'(count), 80'd3);
    chk("t2_dat_c3", 80'(bus.out_dat), 80'hA);
    step();
    chk("t2_count_c4", 80'(count), 80'd2);
    chk("t2_dat_c4", 80'(bus.out_dat), 80'hB);
    step();
    chk("t2_count_c5", 80'(count), 80'd1);
    chk("t2_dat_c5", 80'(bus.out_dat), 80'hC);
    step();
    chk("t2_count_c6", 80'(count), 80'd0);

    // overflow drops the fifth bundle
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push1(70'hD0 + 70'(i), 1'b1);
    push1(70'hD4, 1'b0);
    chk("t3_count", 80'(count), 80'd4);
    chk("t3_full", 80'(full), 80'd1);
    chk("t3_ovf", 80'(ovf_err), 80'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_ovf_clr", 80'(ovf_err), 80'd0);

    // push into a full FIFO while the head pops
    bus.out_rdy = 1'b1;
    push1(70'hAA, 1'b1);
    chk("t4_count", 80'(count), 80'd4);
    chk("t4_full", 80'(full), 80'd1);
    chk("t4_ovf", 80'(ovf_err), 80'd0);
    wait_empty();

    // lden freeze
    push1(70'h55, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("t5_vld_c%0d", c), 80'(bus.out_vld), 80'd0);
      lden = (c >= 4);
      step();
    end
    chk("t5_vld_c6", 80'(bus.out_vld), 80'd1);
    chk("t5_dat_c6", 80'(bus.out_dat), 80'h55);
    step();
    chk("t5_count_c7", 80'(count), 80'd0);
    lden = 1'b0;
    push1(70'h66, 1'b0);
    chk("t5_gated_count", 80'(count), 80'd0);
    step();
    chk("t5_gated_vld", 80'(bus.out_vld), 80'd0);
    lden = 1'b1;

    // flush beats push and pop
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push1(70'hF0 + 70'(i), 1'b1);
    chk("t6_count3", 80'(count), 80'd3);
    flush = 1'b1; bus.in_vld = 1'b1; bus.in_dat = 70'h77; bus.out_rdy = 1'b1;
    q.delete();
    step();
    flush = 1'b0; bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
    chk("t6_flush_count", 80'(count), 80'd0);
    chk("t6_flush_empty", 80'(empty), 80'd1);
    chk("t6_flush_vld", 80'(bus.out_vld), 80'd0);
    chk("t6_flush_ovf", 80'(ovf_err), 80'd0);

    // overflow wins over err_clr; flush keeps the flag
    for (int i = 0; i < 4; i++) push1(70'hE0 + 70'(i), 1'b1);
    err_clr = 1'b1;
    push1(70'hE4, 1'b0);
    err_clr = 1'b0;
    chk("t6_ovf_vs_clr", 80'(ovf_err), 80'd1);
    chk("t6_ovf_count", 80'(count), 80'd4);
    flush = 1'b1;
    q.delete();
    step();
    flush = 1'b0;
    chk("t6_flush_keeps_ovf", 80'(ovf_err), 80'd1);
    chk("t6_flush2_count", 80'(count), 80'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t6_clr_alone", 80'(ovf_err), 80'd0);

    // reset mid-drain
    for (int i = 0; i < 4; i++) push1(70'hC0 + 70'(i), 1'b1);
    push1(70'hC4, 1'b0);
    chk("t7_ovf_set", 80'(ovf_err), 80'd1);
    bus.out_rdy = 1'b1;
    step(); step();
    chk("t7_count2", 80'(count), 80'd2);
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    chk("t7_rst_count", 80'(count), 80'd0);
    chk("t7_rst_vld", 80'(bus.out_vld), 80'd0);
    chk("t7_rst_ovf", 80'(ovf_err), 80'd0);
    push1(70'h3C, 1'b1);
    chk("t7_vld_c1", 80'(bus.out_vld), 80'd0);
    step();
    chk("t7_vld_c2", 80'(bus.out_vld), 80'd0);
    step();
    chk("t7_vld_c3", 80'(bus.out_vld), 80'd1);
    chk("t7_dat_c3", 80'(bus.out_dat), 80'h3C);
    wait_empty();
    chk("sb_leftover", 80'(q.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
